sifive_reset_sequencer: RTL and testbench

Parametrised single-clock reset generator. It is the successor to the fixed hold/sync chain used on the board-level reset path.
- Captures power-on `areset` with asynchronous assert and synchronous deassert.
- Glitch-filters an external reset request and accepts a software reset request.
- Holds all outputs for a configurable count, then releases NUM_OUT reset outputs in index order with a programmable gap.
- Reports the cause of the last reset.

---
 rtl/sifive_reset_pkg.sv | 21 ++
 rtl/sifive_reset_sync_n.sv | 23 ++
 rtl/sifive_reset_sequencer.sv | 152 +++++++++++++++
 tb/tb_sifive_reset_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sifive_reset_pkg.sv
// rtl/sifive_reset_pkg.sv - shared types, cause encodings and width helper for the reset sequencer
package sifive_reset_pkg;

    localparam logic [1:0] CAUSE_AREQ = 2'd0;
    localparam logic [1:0] CAUSE_EXT  = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        RUN   = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/sifive_reset_sync_n.sv
// rtl/sifive_reset_sync_n.sv - flop chain with async set; shifts d_i toward q_o
module sifive_reset_sync_n #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic set_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk_i or posedge set_i) begin
        if (set_i) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/sifive_reset_sequencer.sv
// rtl/sifive_reset_sequencer.sv - staged reset generator: hold, in-order release, glitch-filtered
// external request, software request and last-cause reporting
module sifive_reset_sequencer
    import sifive_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 4,
    parameter int HOLD_BITS   = 8,
    parameter int NUM_OUT     = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int FILTER_LEN  = 4
) (
    input  logic               clock,
    input  logic               areset,
    input  logic               ext_req,
    input  logic               sw_req,
    output logic [NUM_OUT-1:0] reset_out,
    output logic               ready,
    output logic [1:0]         cause
);

    localparam int GAP_W  = clog2(GAP_CYCLES + 1);
    localparam int IDX_W  = clog2(NUM_OUT + 1);
    localparam int FILT_W = clog2(FILTER_LEN + 1);

    localparam logic [HOLD_BITS-1:0] HOLD_MAX   = '1;
    localparam logic [GAP_W-1:0]     GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_OUT - 1);
    localparam logic [FILT_W-1:0]    FILT_MAX   = FILT_W'(FILTER_LEN);

    logic rst_int;
    logic ext_sync;
    logic ext_hit;
    logic req;

    state_e               state_q, state_d;
    logic [HOLD_BITS-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FILT_W-1:0]    filt_q, filt_d;
    logic [NUM_OUT-1:0]   out_q, out_d;
    logic                 ready_q, ready_d;
    logic [1:0]           cause_q, cause_d;

    // areset asserts immediately through the async set and releases after SYNC_STAGES edges
    sifive_reset_sync_n #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clk_i (clock),
        .set_i (areset),
        .d_i   (1'b0),
        .q_o   (rst_int)
    );

    sifive_reset_sync_n #(.STAGES(SYNC_STAGES)) u_ext_sync (
        .clk_i (clock),
        .set_i (1'b0),
        .d_i   (ext_req),
        .q_o   (ext_sync)
    );

    assign ext_hit = (filt_q == FILT_MAX);
    assign req     = ext_hit | sw_req;

    always_comb begin
        filt_d = '0;
        if (ext_sync) begin
            filt_d = (filt_q == FILT_MAX) ? filt_q : filt_q + FILT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        out_d   = out_q;
        ready_d = ready_q;
        cause_d = cause_q;

        if (req) begin
            cause_d = ext_hit ? CAUSE_EXT : CAUSE_SW;
        end

        case (state_q)
            HOLD: begin
                if (req) begin
                    hold_d = HOLD_MAX;
                end else if (hold_q == '0) begin
                    out_d[0] = 1'b0;
                    idx_d    = IDX_W'(1);
                    gap_d    = GAP_RELOAD;
                    state_d  = (NUM_OUT == 1) ? RUN : STAGE;
                    ready_d  = (NUM_OUT == 1);
                end else begin
                    hold_d = hold_q - HOLD_BITS'(1);
                end
            end
            STAGE, RUN: begin
                if (req) begin
                    state_d = HOLD;
                    hold_d  = HOLD_MAX;
                    gap_d   = '0;
                    idx_d   = '0;
                    out_d   = '1;
                    ready_d = 1'b0;
                end else if (state_q == STAGE) begin
                    if (gap_q == '0) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (idx_q == IDX_W'(i)) out_d[i] = 1'b0;
                        end
                        idx_d = idx_q + IDX_W'(1);
                        gap_d = GAP_RELOAD;
                        if (idx_q == LAST_IDX) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst_int) begin
        if (rst_int) begin
            state_q <= HOLD;
            hold_q  <= HOLD_MAX;
            gap_q   <= '0;
            idx_q   <= '0;
            filt_q  <= '0;
            out_q   <= '1;
            ready_q <= 1'b0;
            cause_q <= CAUSE_AREQ;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            filt_q  <= filt_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign reset_out = out_q;
    assign ready     = ready_q;
    assign cause     = cause_q;

endmodule

// File: tb/tb_sifive_reset_sequencer.sv
// tb/tb_sifive_reset_sequencer.sv - self-checking bench: directed table, corner sequences, random vs model
module tb_sifive_reset_sequencer;

    localparam int SYNC = 2;
    localparam int HB   = 4;
    localparam int NO   = 3;
    localparam int GAP  = 3;
    localparam int FL   = 4;
    localparam int HOLD_CYC = 1 << HB;
    localparam logic [31:0] FMASK = (32'd1 << FL) - 32'd1;

    logic          clock;
    logic          areset;
    logic          ext_req;
    logic          sw_req;
    logic [NO-1:0] reset_out;
    logic          ready;
    logic [1:0]    cause;
    bit            clk_en;

    int passed;
    int total;

    // reference model: every output is a function of the edge index and the last accepted request
    int          n;
    int          last_req;
    int          live_from;
    bit          areset_held;
    logic [1:0]  cause_m;
    logic [31:0] hist;

    typedef struct {
        string      name;
        int         cycles;
        bit         ext;
        bit         sw;
        logic [2:0] out;
        bit         rdy;
        logic [1:0] cse;
    } vec_t;

    vec_t tbl[22];

    sifive_reset_sequencer #(
        .SYNC_STAGES (SYNC),
        .HOLD_BITS   (HB),
        .NUM_OUT     (NO),
        .GAP_CYCLES  (GAP),
        .FILTER_LEN  (FL)
    ) dut (
        .clock     (clock),
        .areset    (areset),
        .ext_req   (ext_req),
        .sw_req    (sw_req),
        .reset_out (reset_out),
        .ready     (ready),
        .cause     (cause)
    );

    always #5 if (clk_en) clock = ~clock;

    function automatic logic [NO-1:0] exp_out();
        logic [NO-1:0] r;
        for (int i = 0; i < NO; i++) r[i] = (n < last_req + HOLD_CYC + GAP * i);
        return r;
    endfunction

    function automatic logic exp_ready();
        return (n >= last_req + HOLD_CYC + GAP * (NO - 1));
    endfunction

    task automatic check_model(input string tag);
        logic [NO-1:0] eo;
        logic          er;
        eo = exp_out();
        er = exp_ready();
        total++;
        if (reset_out === eo && ready === er && cause === cause_m) begin
            passed++;
        end else begin
            $display("FAIL %s edge %0d: got out=%b ready=%b cause=%0d, expected out=%b ready=%b cause=%0d",
                     tag, n, reset_out, ready, cause, eo, er, cause_m);
        end
    endtask

    task automatic check_const(input string tag, input logic [2:0] eo, input logic er, input logic [1:0] ec);
        total++;
        if (reset_out === eo && ready === er && cause === ec) begin
            passed++;
        end else begin
            $display("FAIL %s edge %0d: got out=%b ready=%b cause=%0d, expected out=%b ready=%b cause=%0d",
                     tag, n, reset_out, ready, cause, eo, er, ec);
        end
    endtask

    task automatic step(input bit ext, input bit sw, input string tag);
        bit hit;
        ext_req = ext;
        sw_req  = sw;
        @(posedge clock);
        n++;
        hist = {hist[30:0], ext};
        hit  = (((hist >> (SYNC + 1)) & FMASK) == FMASK);
        if (areset_held || n < live_from) begin
            last_req = n;
            cause_m  = 2'd0;
        end else if (hit || sw) begin
            last_req = n;
            cause_m  = hit ? 2'd1 : 2'd2;
        end
        #1;
        check_model(tag);
    endtask

    task automatic areset_on(input string tag);
        areset = 1'b1;
        #1;
        areset_held = 1'b1;
        last_req    = n;
        cause_m     = 2'd0;
        hist        = '0;
        check_model(tag);
        check_const({tag, "_const"}, 3'b111, 1'b0, 2'd0);
    endtask

    task automatic areset_off();
        areset      = 1'b0;
        areset_held = 1'b0;
        live_from   = n + SYNC + 1;
    endtask

    task automatic release_seq(input string tag);
        for (int k = 1; k <= 24; k++) begin
            step(1'b0, 1'b0, tag);
            if (k == 17) check_const({tag, "_hold"}, 3'b111, 1'b0, 2'd0);
            if (k == 18) check_const({tag, "_rel0"}, 3'b110, 1'b0, 2'd0);
            if (k == 21) check_const({tag, "_rel1"}, 3'b100, 1'b0, 2'd0);
            if (k == 24) check_const({tag, "_rel2"}, 3'b000, 1'b1, 2'd0);
        end
    endtask

    initial begin
        clock       = 1'b0;
        clk_en      = 1'b1;
        areset      = 1'b0;
        ext_req     = 1'b0;
        sw_req      = 1'b0;
        passed      = 0;
        total       = 0;
        n           = 0;
        last_req    = 0;
        live_from   = 0;
        areset_held = 1'b0;
        cause_m     = 2'd0;
        hist        = '0;

        tbl[0]  = '{"sw_pulse",       1, 1'b0, 1'b1, 3'b111, 1'b0, 2'd2};
        tbl[1]  = '{"sw_hold",       15, 1'b0, 1'b0, 3'b111, 1'b0, 2'd2};
        tbl[2]  = '{"sw_rel0",        1, 1'b0, 1'b0, 3'b110, 1'b0, 2'd2};
        tbl[3]  = '{"sw_rel1",        3, 1'b0, 1'b0, 3'b100, 1'b0, 2'd2};
        tbl[4]  = '{"sw_rel2",        3, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[5]  = '{"ext_glitch3",    3, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[6]  = '{"ext_glitch_idle",10, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[7]  = '{"ext_long6",      6, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[8]  = '{"ext_hit",        1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd1};
        tbl[9]  = '{"ext_tail",       2, 1'b0, 1'b0, 3'b111, 1'b0, 2'd1};
        tbl[10] = '{"ext_hold",      15, 1'b0, 1'b0, 3'b111, 1'b0, 2'd1};
        tbl[11] = '{"ext_rel0",       1, 1'b0, 1'b0, 3'b110, 1'b0, 2'd1};
        tbl[12] = '{"stage_wait",     1, 1'b0, 1'b0, 3'b110, 1'b0, 2'd1};
        tbl[13] = '{"stage_sw",       1, 1'b0, 1'b1, 3'b111, 1'b0, 2'd2};
        tbl[14] = '{"stage_rehold",  16, 1'b0, 1'b0, 3'b110, 1'b0, 2'd2};
        tbl[15] = '{"stage_done",     6, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[16] = '{"sim_ext4",       4, 1'b1, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[17] = '{"sim_gap",        2, 1'b0, 1'b0, 3'b000, 1'b1, 2'd2};
        tbl[18] = '{"sim_both",       1, 1'b0, 1'b1, 3'b111, 1'b0, 2'd1};
        tbl[19] = '{"sim_hold",      15, 1'b0, 1'b0, 3'b111, 1'b0, 2'd1};
        tbl[20] = '{"sim_rel0",       1, 1'b0, 1'b0, 3'b110, 1'b0, 2'd1};
        tbl[21] = '{"sim_done",       6, 1'b0, 1'b0, 3'b000, 1'b1, 2'd1};

        #1;
        areset_on("por_async");
        repeat (5) step(1'b0, 1'b0, "por_held");
        areset_off();
        release_seq("por");

        for (int r = 0; r < 22; r++) begin
            for (int c = 0; c < tbl[r].cycles; c++) begin
                step(tbl[r].ext, tbl[r].sw, tbl[r].name);
            end
            check_const({tbl[r].name, "_end"}, tbl[r].out, tbl[r].rdy, tbl[r].cse);
        end

        // async re-entry with the clock parked low
        @(negedge clock);
        clk_en = 1'b0;
        #20;
        areset_on("reentry_async");
        #20;
        check_const("reentry_stopped", 3'b111, 1'b0, 2'd0);
        areset_off();
        #20;
        check_const("reentry_released_noclk", 3'b111, 1'b0, 2'd0);
        clk_en = 1'b1;
        release_seq("reentry");

        begin
            bit ext_lvl;
            bit sw;
            ext_lvl = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if (ext_lvl) ext_lvl = ($urandom_range(0, 3) != 0);
                else         ext_lvl = ($urandom_range(0, 39) == 0);
                sw = ($urandom_range(0, 59) == 0);
                step(ext_lvl, sw, "random");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
